// File: rtl/mxu_array_ctrl.sv
// Weight-preload / activation-stream controller for an NxN systolic PE array.
// Optional macro MXU_CTRL_SKEW_EN staggers activation lanes by row index (row r lags row 0 by r cycles).
module mxu_array_ctrl #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_vectors,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [8*N-1:0]   w_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [8*N-1:0]   a_data,
  output logic             load_phase,
  output logic [7:0]       load_weight_target_y,
  output logic [8*N-1:0]   load_weight,
  output logic [8*N-1:0]   act_out,
  output logic [N-1:0]     act_valid,
  output logic             busy,
  output logic             done
);

`ifdef MXU_CTRL_SKEW_EN
  localparam int DRAIN_LEN = 2 * N;
`else
  localparam int DRAIN_LEN = N + 1;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       y_q, y_d;
  logic [7:0]       vec_q, vec_d;
  logic [7:0]       drn_q, drn_d;
  logic             lp_q, lp_d;
  logic [7:0]       ty_q, ty_d;
  logic [8*N-1:0]   lw_q, lw_d;
  logic             w_hs, a_hs;

  assign w_ready = (state_q == LOAD);
  assign a_ready = (state_q == STREAM);
  assign w_hs    = w_valid & w_ready;
  assign a_hs    = a_valid & a_ready;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  assign load_phase           = lp_q;
  assign load_weight_target_y = ty_q;
  assign load_weight          = lw_q;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    y_d     = y_q;
    vec_d   = vec_q;
    drn_d   = drn_q;
    lp_d    = w_hs;
    ty_d    = w_hs ? y_q : ty_q;
    lw_d    = w_hs ? w_data : lw_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_vectors;
          y_d     = 8'd0;
          vec_d   = 8'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (w_hs) begin
          y_d = y_q + 8'd1;
          if (y_q == 8'(N - 1)) begin
            drn_d   = 8'd0;
            state_d = (num_q == 8'd0) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        // compare against num-1 so that 255 finishes before the counter could wrap
        if (a_hs) begin
          vec_d = vec_q + 8'd1;
          if (vec_q == num_q - 8'd1) begin
            drn_d   = 8'd0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drn_d = drn_q + 8'd1;
        if (drn_q == 8'(DRAIN_LEN - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      y_q     <= '0;
      vec_q   <= '0;
      drn_q   <= '0;
      lp_q    <= 1'b0;
      ty_q    <= '0;
      lw_q    <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      y_q     <= y_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
      lp_q    <= lp_d;
      ty_q    <= ty_d;
      lw_q    <= lw_d;
    end
  end

`ifdef MXU_CTRL_SKEW_EN
  // Lane r is a shift register of depth r+1; idle cycles shift in zero bubbles.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [r:0][7:0] dat_q, dat_d;
    logic [r:0]      vld_pipe_q, vld_pipe_d;

    always_comb begin
      dat_d         = dat_q;
      vld_pipe_d    = vld_pipe_q;
      dat_d[0]      = a_hs ? a_data[8*r +: 8] : 8'h00;
      vld_pipe_d[0] = a_hs;
      for (int k = 1; k <= r; k++) begin
        dat_d[k]      = dat_q[k-1];
        vld_pipe_d[k] = vld_pipe_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q      <= '0;
        vld_pipe_q <= '0;
      end else begin
        dat_q      <= dat_d;
        vld_pipe_q <= vld_pipe_d;
      end
    end

    assign act_out[8*r +: 8] = dat_q[r];
    assign act_valid[r]      = vld_pipe_q[r];
  end
`else
  logic [8*N-1:0] act_q, act_d;
  logic [N-1:0]   av_q, av_d;

  always_comb begin
    act_d = a_hs ? a_data : '0;
    av_d  = {N{a_hs}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      av_q  <= '0;
    end else begin
      act_q <= act_d;
      av_q  <= av_d;
    end
  end

  assign act_out   = act_q;
  assign act_valid = av_q;
`endif

endmodule

// File: doc/mxu_array_ctrl.md
MXU_ARRAY_CTRL -- requirements
Module: mxu_array_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the PE array dimension (rows = columns = N, 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle job start request.
REQ-005 The block SHALL have port num_vectors, input, 8, the number of activation vectors per job, sampled on accepted start.
REQ-006 The block SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, 8*N): the weight-row stream, one row per beat, lane c = column c.
REQ-007 The block SHALL have ports a_valid (input, 1), a_ready (output, 1) and a_data (input, 8*N): the activation-vector stream, lane r = array row r.
REQ-008 The block SHALL have port load_phase, output, 1, the preload phase driven to the array top.
REQ-009 The block SHALL have port load_weight_target_y, output, 8, the target PE y-index for preload.
REQ-010 The block SHALL have port load_weight, output, 8*N, the per-column weights for preload.
REQ-011 The block SHALL have ports act_out (output, 8*N) and act_valid (output, N): the per-row activations and per-row valids driven to the array left edge.
REQ-012 The block SHALL have ports busy (output, 1), high whenever the state is not IDLE, and done (output, 1), a one-cycle job-complete pulse.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch num_vectors, clear row counter y, and enter LOAD; start in any other state SHALL be ignored.
REQ-015 In LOAD, w_ready SHALL be 1 and a_ready SHALL be 0.
REQ-016 For each w handshake at cycle t, the outputs at t+1 SHALL be load_phase=1, load_weight_target_y=y and load_weight=w_data, and y SHALL increment.
REQ-017 With no w handshake in a cycle, load_phase SHALL be 0 in the next cycle, and load_weight/load_weight_target_y SHALL hold their values.
REQ-018 After handshake y=N-1, the FSM SHALL go to STREAM, or directly to DRAIN if the latched num_vectors=0.
REQ-019 In STREAM, a_ready SHALL be 1 and w_ready SHALL be 0; each a handshake SHALL increment the vector counter, and after the num_vectors-th handshake the FSM SHALL go to DRAIN.
REQ-020 With skew enabled, an a handshake at cycle t SHALL put lane r of a_data on act_out lane r with act_valid[r]=1 at cycle t+1+r.
REQ-021 A cycle with no a handshake SHALL inject a bubble: the affected lane gets act_out=0 and act_valid=0 at the same skewed offset.
REQ-022 DRAIN SHALL last exactly 2N cycles and be followed by DONE.
REQ-023 While in DRAIN, a_ready and w_ready SHALL both be 0, and the skew pipeline SHALL continue shifting bubbles.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 The vector counter SHALL be 8 bits; num_vectors=255 SHALL complete without wrap.

Reset
REQ-026 When rst=1 at a clock edge, the state SHALL become IDLE, and all counters and skew registers SHALL clear.
REQ-027 On reset, load_phase, load_weight_target_y, load_weight, act_out, act_valid, w_ready, a_ready, busy and done SHALL all become 0.
REQ-028 Reset mid-job SHALL abort the job with no done pulse, and no partial state SHALL survive into the next job.

Configuration
REQ-029 With macro MXU_CTRL_SKEW_EN defined, activation lanes SHALL be skewed as in REQ-020, and DRAIN SHALL last 2N cycles.
REQ-030 Without MXU_CTRL_SKEW_EN, every lane SHALL appear at t+1 (no skew, all act_valid bits equal), DRAIN SHALL last N+1 cycles, and the skew registers SHALL be absent.

Verification
REQ-031 Scenario (N=4, skew on): start with num_vectors=2, then weight rows 0x01..0x04 back-to-back -> load_phase high 4 cycles with target_y 0,1,2,3, then STREAM; done pulses exactly 8 cycles after DRAIN entry.
REQ-032 Scenario: a_data lanes {0x10,0x20,0x30,0x40} accepted at t -> act_out lane0=0x10 at t+1, lane1=0x20 at t+2, lane2=0x30 at t+3, lane3=0x40 at t+4, each with its act_valid bit set only then.
REQ-033 Scenario: w_valid toggled 1,0,1,0 during LOAD -> load_phase pattern 1,0,1,0, target_y advances only on handshakes, and a_ready stays 0.
REQ-034 Scenario: num_vectors=0 -> after 4 weight rows, no a_ready cycle, DRAIN of 8 cycles, single done pulse.
REQ-035 Scenario: rst asserted in STREAM after 1 of 3 vectors -> next cycle all outputs 0 and busy=0; a fresh job then completes normally.
REQ-036 Scenario: start pulsed while busy -> ignored, with no change to counters or the latched num_vectors.
